// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types for the pipeline hazard controller: writeback classes, controller states
// and the register-match helper used by hazard detection.
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC  = 2'd2,
        WB_CSR = 2'd3
    } writebackType_;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        TRAP_FLUSH = 2'd2
    } hazardState_;

    // x0 never creates a dependency, so a zero source register never matches
    function automatic logic regMatch(input logic [4:0] rs, input logic uses, input logic [4:0] rd);
        return uses && (rs != 5'd0) && (rs == rd);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Pure combinational load-use and CSR read-after-write hazard detection for the IF/ID instruction.
module hazard_detect
    import pipeline_hazard_controller_pkg::*;
(
    input  logic [4:0]    fetchDecodeRegister1,
    input  logic [4:0]    fetchDecodeRegister2,
    input  logic          fetchDecodeUsesRs1,
    input  logic          fetchDecodeUsesRs2,
    input  logic          fetchDecodeValid,
    input  logic          fetchDecodeCSRRead,
    input  logic [4:0]    decodeExecuteDestinationRegister,
    input  writebackType_ decodeExecuteWritebackType,
    input  logic          decodeExecuteValid,
    input  logic          decodeExecuteCSRWriteIntent,
    input  logic [4:0]    executeMemoryDestinationRegister,
    input  writebackType_ executeMemoryWritebackType,
    input  logic          executeMemoryValid,
    output logic          loadUse,
    output logic          csrHazard
);

    logic decodeExecuteLoad;
    logic executeMemoryLoad;
    logic matchDecodeExecute;
    logic matchExecuteMemory;

    // Loads forward only from MEM/WB, so a load still in ID/EX or EX/MEM blocks its consumer
    always_comb begin
        decodeExecuteLoad  = decodeExecuteValid && (decodeExecuteWritebackType == WB_MEM);
        executeMemoryLoad  = executeMemoryValid && (executeMemoryWritebackType == WB_MEM);
        matchDecodeExecute = regMatch(fetchDecodeRegister1, fetchDecodeUsesRs1, decodeExecuteDestinationRegister)
                          || regMatch(fetchDecodeRegister2, fetchDecodeUsesRs2, decodeExecuteDestinationRegister);
        matchExecuteMemory = regMatch(fetchDecodeRegister1, fetchDecodeUsesRs1, executeMemoryDestinationRegister)
                          || regMatch(fetchDecodeRegister2, fetchDecodeUsesRs2, executeMemoryDestinationRegister);
        loadUse   = fetchDecodeValid && ((decodeExecuteLoad && matchDecodeExecute)
                                      || (executeMemoryLoad && matchExecuteMemory));
        csrHazard = fetchDecodeValid && fetchDecodeCSRRead && decodeExecuteValid && decodeExecuteCSRWriteIntent;
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage core: load-use/CSR bubbles, data-memory waits, branch/trap squash.
// Optional performance counters are built when HAZARD_PERF_COUNTERS_EN is defined.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int unsigned TRAP_FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT       = 255
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [4:0]    fetchDecodeRegister1,
    input  logic [4:0]    fetchDecodeRegister2,
    input  logic          fetchDecodeUsesRs1,
    input  logic          fetchDecodeUsesRs2,
    input  logic          fetchDecodeValid,
    input  logic          fetchDecodeCSRRead,
    input  logic [4:0]    decodeExecuteDestinationRegister,
    input  writebackType_ decodeExecuteWritebackType,
    input  logic          decodeExecuteValid,
    input  logic          decodeExecuteCSRWriteIntent,
    input  logic [4:0]    executeMemoryDestinationRegister,
    input  writebackType_ executeMemoryWritebackType,
    input  logic          executeMemoryValid,
    input  logic          memRequest,
    input  logic          memReady,
    input  logic          branchTaken,
    input  logic          trapRequest,
    output logic          stallFetch,
    output logic          stallDecode,
    output logic          stallExecute,
    output logic          stallMemory,
    output logic          flushDecode,
    output logic          flushExecute,
    output logic          flushMemory,
    output logic          memTimeout,
`ifdef HAZARD_PERF_COUNTERS_EN
    output logic [31:0]   loadUseStallCount,
    output logic [31:0]   memWaitCycleCount,
    output logic [31:0]   flushEventCount,
`endif
    output logic [1:0]    controllerState
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [3:0]        TRAP_LOAD = 4'(TRAP_FLUSH_CYCLES - 1);

    hazardState_       state;
    hazardState_       stateNext;
    logic [3:0]        trapCount;
    logic [WAIT_W-1:0] waitCount;
    logic              trapLoad;
    logic              waitStart;
    logic              memStall;
    logic              loadUse;
    logic              csrHazard;
    logic              rawStallFetch, rawStallDecode, rawStallExecute, rawStallMemory;
    logic              rawFlushDecode, rawFlushExecute, rawFlushMemory;

    hazard_detect detect (
        .fetchDecodeRegister1             (fetchDecodeRegister1),
        .fetchDecodeRegister2             (fetchDecodeRegister2),
        .fetchDecodeUsesRs1               (fetchDecodeUsesRs1),
        .fetchDecodeUsesRs2               (fetchDecodeUsesRs2),
        .fetchDecodeValid                 (fetchDecodeValid),
        .fetchDecodeCSRRead               (fetchDecodeCSRRead),
        .decodeExecuteDestinationRegister (decodeExecuteDestinationRegister),
        .decodeExecuteWritebackType       (decodeExecuteWritebackType),
        .decodeExecuteValid               (decodeExecuteValid),
        .decodeExecuteCSRWriteIntent      (decodeExecuteCSRWriteIntent),
        .executeMemoryDestinationRegister (executeMemoryDestinationRegister),
        .executeMemoryWritebackType       (executeMemoryWritebackType),
        .executeMemoryValid               (executeMemoryValid),
        .loadUse                          (loadUse),
        .csrHazard                        (csrHazard)
    );

    always_comb begin
        stateNext       = state;
        trapLoad        = 1'b0;
        waitStart       = 1'b0;
        rawStallFetch   = 1'b0;
        rawStallDecode  = 1'b0;
        rawStallExecute = 1'b0;
        rawStallMemory  = 1'b0;
        rawFlushDecode  = 1'b0;
        rawFlushExecute = 1'b0;
        rawFlushMemory  = 1'b0;
        // Once frozen, only memReady releases the wait; from RUN a fresh unready request starts one
        memStall = (state == MEM_WAIT) ? !memReady : (memRequest && !memReady);

        if (trapRequest) begin
            stateNext       = TRAP_FLUSH;
            trapLoad        = 1'b1;
            rawFlushDecode  = 1'b1;
            rawFlushExecute = 1'b1;
            rawFlushMemory  = 1'b1;
        end else if (state == TRAP_FLUSH) begin
            rawFlushDecode  = 1'b1;
            rawFlushExecute = 1'b1;
            rawFlushMemory  = 1'b1;
            if (trapCount == 4'd0) begin
                stateNext = RUN;
            end
        end else if (memStall) begin
            stateNext       = MEM_WAIT;
            waitStart       = (state != MEM_WAIT);
            rawStallFetch   = 1'b1;
            rawStallDecode  = 1'b1;
            rawStallExecute = 1'b1;
            rawStallMemory  = 1'b1;
        end else begin
            stateNext = RUN;
            if (branchTaken) begin
                rawFlushDecode  = 1'b1;
                rawFlushExecute = 1'b1;
            end else if (loadUse || csrHazard) begin
                rawStallFetch   = 1'b1;
                rawStallDecode  = 1'b1;
                rawFlushExecute = 1'b1;
            end
        end
    end

    // Flush overrides stall on the same stage; everything is quiet while reset is held
    always_comb begin
        stallFetch   = !reset && rawStallFetch;
        stallDecode  = !reset && rawStallDecode  && !rawFlushDecode;
        stallExecute = !reset && rawStallExecute && !rawFlushExecute;
        stallMemory  = !reset && rawStallMemory  && !rawFlushMemory;
        flushDecode  = !reset && rawFlushDecode;
        flushExecute = !reset && rawFlushExecute;
        flushMemory  = !reset && rawFlushMemory;
        controllerState = state;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            trapCount  <= '0;
            waitCount  <= '0;
            memTimeout <= 1'b0;
        end else begin
            state <= stateNext;
            if (trapLoad) begin
                trapCount <= TRAP_LOAD;
            end else if (state == TRAP_FLUSH && trapCount != 4'd0) begin
                trapCount <= trapCount - 4'd1;
            end
            if (waitStart) begin
                waitCount <= WAIT_W'(1);
            end else if (state == MEM_WAIT && waitCount < WAIT_MAX) begin
                waitCount <= waitCount + WAIT_W'(1);
            end
            if (state == MEM_WAIT && MEM_TIMEOUT != 0 && waitCount == WAIT_MAX) begin
                memTimeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    // A load-use bubble is the hazard path (decode held, execute not) caused by a load
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            loadUseStallCount <= '0;
            memWaitCycleCount <= '0;
            flushEventCount   <= '0;
        end else begin
            if (rawStallDecode && !rawStallExecute && loadUse) begin
                loadUseStallCount <= loadUseStallCount + 32'd1;
            end
            if (state == MEM_WAIT) begin
                memWaitCycleCount <= memWaitCycleCount + 32'd1;
            end
            if (trapRequest || (rawFlushDecode && !rawFlushMemory)) begin
                flushEventCount <= flushEventCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed scoreboard bench for pipeline_hazard_controller (TRAP_FLUSH_CYCLES=2, MEM_TIMEOUT=3).
module tb_pipeline_hazard_controller;
    import pipeline_hazard_controller_pkg::*;

    logic          clock;
    logic          reset;
    logic [4:0]    fetchDecodeRegister1, fetchDecodeRegister2;
    logic          fetchDecodeUsesRs1, fetchDecodeUsesRs2, fetchDecodeValid, fetchDecodeCSRRead;
    logic [4:0]    decodeExecuteDestinationRegister;
    writebackType_ decodeExecuteWritebackType;
    logic          decodeExecuteValid, decodeExecuteCSRWriteIntent;
    logic [4:0]    executeMemoryDestinationRegister;
    writebackType_ executeMemoryWritebackType;
    logic          executeMemoryValid;
    logic          memRequest, memReady, branchTaken, trapRequest;
    logic          stallFetch, stallDecode, stallExecute, stallMemory;
    logic          flushDecode, flushExecute, flushMemory, memTimeout;
    logic [1:0]    controllerState;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0]   loadUseStallCount, memWaitCycleCount, flushEventCount;
`endif

    pipeline_hazard_controller #(
        .TRAP_FLUSH_CYCLES (2),
        .MEM_TIMEOUT       (3)
    ) dut (
        .clock                            (clock),
        .reset                            (reset),
        .fetchDecodeRegister1             (fetchDecodeRegister1),
        .fetchDecodeRegister2             (fetchDecodeRegister2),
        .fetchDecodeUsesRs1               (fetchDecodeUsesRs1),
        .fetchDecodeUsesRs2               (fetchDecodeUsesRs2),
        .fetchDecodeValid                 (fetchDecodeValid),
        .fetchDecodeCSRRead               (fetchDecodeCSRRead),
        .decodeExecuteDestinationRegister (decodeExecuteDestinationRegister),
        .decodeExecuteWritebackType       (decodeExecuteWritebackType),
        .decodeExecuteValid               (decodeExecuteValid),
        .decodeExecuteCSRWriteIntent      (decodeExecuteCSRWriteIntent),
        .executeMemoryDestinationRegister (executeMemoryDestinationRegister),
        .executeMemoryWritebackType       (executeMemoryWritebackType),
        .executeMemoryValid               (executeMemoryValid),
        .memRequest                       (memRequest),
        .memReady                         (memReady),
        .branchTaken                      (branchTaken),
        .trapRequest                      (trapRequest),
        .stallFetch                       (stallFetch),
        .stallDecode                      (stallDecode),
        .stallExecute                     (stallExecute),
        .stallMemory                      (stallMemory),
        .flushDecode                      (flushDecode),
        .flushExecute                     (flushExecute),
        .flushMemory                      (flushMemory),
        .memTimeout                       (memTimeout),
`ifdef HAZARD_PERF_COUNTERS_EN
        .loadUseStallCount                (loadUseStallCount),
        .memWaitCycleCount                (memWaitCycleCount),
        .flushEventCount                  (flushEventCount),
`endif
        .controllerState                  (controllerState)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected vector layout: {stallF,stallD,stallE,stallM, flushD,flushE,flushM, memTimeout, state[1:0]}
    typedef struct {
        string      tag;
        logic [9:0] v;
    } expect_t;

    expect_t sb[$];
    int      errors = 0;
    int      checks = 0;

    task automatic idle();
        fetchDecodeRegister1 = 5'd0;  fetchDecodeRegister2 = 5'd0;
        fetchDecodeUsesRs1 = 1'b0;    fetchDecodeUsesRs2 = 1'b0;
        fetchDecodeValid = 1'b0;      fetchDecodeCSRRead = 1'b0;
        decodeExecuteDestinationRegister = 5'd0;
        decodeExecuteWritebackType = WB_ALU;
        decodeExecuteValid = 1'b0;    decodeExecuteCSRWriteIntent = 1'b0;
        executeMemoryDestinationRegister = 5'd0;
        executeMemoryWritebackType = WB_ALU;
        executeMemoryValid = 1'b0;
        memRequest = 1'b0; memReady = 1'b0; branchTaken = 1'b0; trapRequest = 1'b0;
    endtask

    // Inputs are set at the falling edge; outputs are sampled 1 time unit later, then one clock elapses
    task automatic cyc(input string tag, input logic [9:0] v);
        expect_t    e;
        logic [9:0] obs;
        sb.push_back('{tag, v});
        #1;
        e   = sb.pop_front();
        obs = {stallFetch, stallDecode, stallExecute, stallMemory,
               flushDecode, flushExecute, flushMemory, memTimeout, controllerState};
        checks++;
        assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic loadInDecodeExecute(input logic [4:0] rd);
        decodeExecuteValid = 1'b1;
        decodeExecuteDestinationRegister = rd;
        decodeExecuteWritebackType = WB_MEM;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        memRequest = 1'b1;
        branchTaken = 1'b1;
        cyc("reset_quiet",  10'b0000_000_0_00);
        reset = 1'b0;
        idle();
        cyc("idle",         10'b0000_000_0_00);

        // Load x5 moves ID/EX -> EX/MEM while the dependent instruction waits in IF/ID
        fetchDecodeValid = 1'b1; fetchDecodeUsesRs1 = 1'b1; fetchDecodeRegister1 = 5'd5;
        loadInDecodeExecute(5'd5);
        cyc("loaduse_1",    10'b1100_010_0_00);
        decodeExecuteValid = 1'b0;
        executeMemoryValid = 1'b1; executeMemoryDestinationRegister = 5'd5;
        executeMemoryWritebackType = WB_MEM;
        cyc("loaduse_2",    10'b1100_010_0_00);
        executeMemoryValid = 1'b0;
        cyc("loaduse_done", 10'b0000_000_0_00);

        fetchDecodeRegister1 = 5'd0;
        loadInDecodeExecute(5'd0);
        cyc("loaduse_x0",   10'b0000_000_0_00);
        fetchDecodeRegister1 = 5'd5; fetchDecodeUsesRs1 = 1'b0;
        loadInDecodeExecute(5'd5);
        cyc("loaduse_nors", 10'b0000_000_0_00);
        fetchDecodeUsesRs2 = 1'b1; fetchDecodeRegister2 = 5'd5;
        cyc("loaduse_rs2",  10'b1100_010_0_00);
        decodeExecuteWritebackType = WB_ALU;
        cyc("alu_no_stall", 10'b0000_000_0_00);

        idle();
        fetchDecodeValid = 1'b1; fetchDecodeCSRRead = 1'b1;
        decodeExecuteValid = 1'b1; decodeExecuteCSRWriteIntent = 1'b1;
        cyc("csr_hazard",   10'b1100_010_0_00);
        idle();
        branchTaken = 1'b1;
        cyc("branch",       10'b0000_110_0_00);
        idle();
        memRequest = 1'b1; memReady = 1'b1;
        cyc("mem_hit",      10'b0000_000_0_00);

        // Four unready cycles; the third MEM_WAIT cycle reaches MEM_TIMEOUT=3
        memReady = 1'b0;
        cyc("memwait_1",    10'b1111_000_0_00);
        cyc("memwait_2",    10'b1111_000_0_01);
        branchTaken = 1'b1;
        cyc("memwait_br",   10'b1111_000_0_01);
        branchTaken = 1'b0;
        cyc("memwait_4",    10'b1111_000_0_01);
        memReady = 1'b1;
        cyc("memwait_rdy",  10'b0000_000_1_01);
        idle();
        cyc("memwait_run",  10'b0000_000_1_00);

        // Trap outranks a simultaneous branch and load-use
        fetchDecodeValid = 1'b1; fetchDecodeUsesRs1 = 1'b1; fetchDecodeRegister1 = 5'd7;
        loadInDecodeExecute(5'd7);
        branchTaken = 1'b1; trapRequest = 1'b1;
        cyc("trap_enter",   10'b0000_111_1_00);
        trapRequest = 1'b0;
        cyc("trap_flush1",  10'b0000_111_1_10);
        cyc("trap_flush2",  10'b0000_111_1_10);
        cyc("trap_run_br",  10'b0000_110_1_00);
        branchTaken = 1'b0;
        cyc("trap_run_lu",  10'b1100_010_1_00);

        idle();
        memRequest = 1'b1;
        cyc("mwtrap_wait",  10'b1111_000_1_00);
        trapRequest = 1'b1;
        cyc("mwtrap_trap",  10'b0000_111_1_01);
        idle();
        cyc("mwtrap_f1",    10'b0000_111_1_10);
        cyc("mwtrap_f2",    10'b0000_111_1_10);
        cyc("mwtrap_run",   10'b0000_000_1_00);

        // Reset mid-wait clears state and memTimeout without a clock edge
        memRequest = 1'b1;
        cyc("rst_wait_a",   10'b1111_000_1_00);
        cyc("rst_wait_b",   10'b1111_000_1_01);
        reset = 1'b1;
        cyc("rst_async",    10'b0000_000_0_00);
        reset = 1'b0;
        cyc("rst_release",  10'b1111_000_0_00);
        cyc("rst_rewait",   10'b1111_000_0_01);
        memReady = 1'b1;
        cyc("rst_ready",    10'b0000_000_0_01);
        idle();
        cyc("rst_run",      10'b0000_000_0_00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage core, in CPU/Control next to the forwarding block.
- Detects load-use and CSR read-after-write hazards that forwarding cannot cover.
- Holds the pipeline while data memory is busy, and squashes younger stages on a branch or trap redirect.
- Drives per-stage stall and flush enables consumed by the pipeline registers.

Parameters:
- TRAP_FLUSH_CYCLES, 2: cycles the front end is held flushed after a trap/mret redirect, in the range 1..15.
- MEM_TIMEOUT, 255: data-memory wait cycles before memTimeout asserts; 0 disables the timeout.

Ports:
- clock  input  1  core clock.
- reset  input  1  asynchronous, active-high reset.
- fetchDecodeRegister1  input  5  rs1 of the instruction in IF/ID.
- fetchDecodeRegister2  input  5  rs2 of the instruction in IF/ID.
- fetchDecodeUsesRs1  input  1  IF/ID instruction reads rs1.
- fetchDecodeUsesRs2  input  1  IF/ID instruction reads rs2.
- fetchDecodeValid  input  1  IF/ID holds a live instruction.
- fetchDecodeCSRRead  input  1  IF/ID instruction is a CSR op.
- decodeExecuteDestinationRegister  input  5  rd in ID/EX.
- decodeExecuteWritebackType  input  writebackType_  writeback type of the ID/EX instruction; WB_MEM marks a load.
- decodeExecuteValid  input  1  ID/EX holds a live instruction.
- decodeExecuteCSRWriteIntent  input  1  ID/EX instruction writes a CSR.
- executeMemoryDestinationRegister  input  5  rd in EX/MEM.
- executeMemoryWritebackType  input  writebackType_  writeback type in EX/MEM.
- executeMemoryValid  input  1  EX/MEM holds a live instruction.
- memRequest  input  1  memory stage has an access outstanding.
- memReady  input  1  data memory completes the access this cycle.
- branchTaken  input  1  execute resolves a taken branch or jump.
- trapRequest  input  1  writeback raises a trap or mret.
- stallFetch, stallDecode, stallExecute, stallMemory  output  1 each  hold the corresponding stage register.
- flushDecode, flushExecute, flushMemory  output  1 each  load a bubble into IF/ID, ID/EX, EX/MEM.
- memTimeout  output  1  sticky error; set when a memory wait exceeds MEM_TIMEOUT.
- controllerState  output  2  current state, for debug.

Behaviour:
- Reset: state RUN, all counters 0, memTimeout 0. Every stall and flush output is 0 while reset is asserted.
- States (shared enum): RUN=0, MEM_WAIT=1, TRAP_FLUSH=2.
- loadUse (combinational) is 1 when fetchDecodeValid and a used rs (nonzero) matches the rd of a valid WB_MEM instruction in either ID/EX or EX/MEM. A load forwards only from MEM/WB, so a dependent instruction can see up to 2 bubbles.
- csrHazard (combinational) is fetchDecodeValid && fetchDecodeCSRRead && decodeExecuteValid && decodeExecuteCSRWriteIntent. This serialises back-to-back CSR ops with 1 bubble.
- RUN:
  - If trapRequest: go to TRAP_FLUSH, assert all flushes this cycle, load trapCount = TRAP_FLUSH_CYCLES-1.
  - Else if memRequest && !memReady: go to MEM_WAIT, assert all four stalls this cycle, waitCount = 1.
  - Else if branchTaken: flushDecode=1 and flushExecute=1 for 1 cycle, no stall.
  - Else if loadUse or csrHazard: stallFetch=1, stallDecode=1, flushExecute=1.
- MEM_WAIT:
  - All four stalls are 1 and all flushes are 0, including a branchTaken that arrived while frozen.
  - waitCount saturates at MEM_TIMEOUT.
  - memTimeout sets when waitCount == MEM_TIMEOUT and MEM_TIMEOUT != 0.
  - On memReady, the stalls drop in that same cycle and the state returns to RUN.
  - trapRequest in MEM_WAIT takes precedence: go to TRAP_FLUSH and flush all stages.
- TRAP_FLUSH:
  - flushDecode=1, flushExecute=1, flushMemory=1, stallFetch=0.
  - trapCount decrements each cycle; the state returns to RUN on the cycle trapCount==0.
  - A new trapRequest reloads trapCount.
- Priority in every state: trap > memory wait > branch > load-use/CSR.
- When a stall and a flush apply to the same stage, the flush wins.
- Reset asserted mid-wait or mid-flush returns to RUN immediately. memTimeout clears only on reset.

Optional Feature:
- Macro: HAZARD_PERF_COUNTERS_EN.
- With the macro defined: 32-bit output ports loadUseStallCount, memWaitCycleCount and flushEventCount are present.
  - loadUseStallCount increments each cycle a load-use bubble is inserted.
  - memWaitCycleCount increments each cycle in MEM_WAIT.
  - flushEventCount increments once per branch or trap event.
  - All three wrap at 2^32 and reset to 0.
- Without the macro: the ports and registers are absent, and all other behaviour is identical.

Decomposition:
- pack gains hazardState_ (RUN/MEM_WAIT/TRAP_FLUSH) and reuses writebackType_.
- One sub-module, hazard_detect: the pure combinational loadUse/csrHazard logic.
- The FSM, counters and output decode stay in the top module.

Test Plan:
- Load x5 in ID/EX; IF/ID reads rs1=x5 -> 2 consecutive cycles of stallFetch=stallDecode=flushExecute=1, then 0.
- Same dependency but rs1=x0, or fetchDecodeUsesRs1=0 -> no stall.
- memRequest=1, memReady=0 for 4 cycles, then 1 -> all stalls high for 4 cycles; RUN in the cycle memReady rises.
- MEM_TIMEOUT=3, memReady never arrives -> memTimeout rises after 3 wait cycles and remains set until reset.
- trapRequest with TRAP_FLUSH_CYCLES=2 while loadUse and branchTaken are high -> 2 cycles of flushDecode/flushExecute/flushMemory=1, no load-use stall, then RUN.
- Reset pulsed during MEM_WAIT -> controllerState=0 and all outputs 0 asynchronously; normal operation on the first clock after release.
